layer_inter_pingpong_control: RTL

Parametrised inter-layer feature-buffer controller with NUM_BANKS rotating banks (ping-pong for NUM_BANKS=2). The former layer writes bank wp while the next layer reads an earlier filled bank rp, so the two layers overlap instead of running serially. It sits between two CNN layer engines and the banked inter-layer feature RAMs. It sequences enable/reset of both layers, tracks bank occupancy, routes RAM control/address per bank, and back-pressures the former layer when all banks are full.

---
 rtl/layer_inter_pingpong_control.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/layer_inter_pingpong_control.sv
// Inter-layer feature-buffer controller with NUM_BANKS rotating banks.
// The former layer fills bank wp while the next layer drains an earlier filled
// bank rp, so the two layer engines overlap. The block starts both layers,
// tracks which banks hold unconsumed data, routes each layer's RAM controls to
// its current bank, and stalls the former layer while every bank is full.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   enable                        permits new layer starts
//   layer_former_done             level; rising edge = write bank complete
//   layer_next_done               level; rising edge = read bank consumed
//   layer_former_enable/_reset    former layer run enable / start pulse
//   layer_next_enable/_reset      next layer run enable / start pulse
//   *_layer_former, *_layer_next  per-layer RAM controls and addresses
//   *_bank                        per-bank RAM controls (bit k / slice k = bank k)
//   wr_bank_sel, rd_bank_sel      current write / read bank pointers
//   bank_full                     bit k set = bank k filled, not yet consumed
//   overflow_err                  sticky; done edge seen outside RUN
module layer_inter_pingpong_control #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned BANK_SEL_WIDTH = 1,
  parameter int unsigned CNT_WIDTH      = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            layer_former_done,
  input  logic                            layer_next_done,
  output logic                            layer_former_enable,
  output logic                            layer_former_reset,
  output logic                            layer_next_enable,
  output logic                            layer_next_reset,
  input  logic                            rden_a_layer_former,
  input  logic                            rden_b_layer_former,
  input  logic                            wren_a_layer_former,
  input  logic                            wren_b_layer_former,
  input  logic [ADDR_WIDTH-1:0]           address_a_layer_former,
  input  logic [ADDR_WIDTH-1:0]           address_b_layer_former,
  input  logic                            rden_a_layer_next,
  input  logic                            rden_b_layer_next,
  input  logic [ADDR_WIDTH-1:0]           address_a_layer_next,
  input  logic [ADDR_WIDTH-1:0]           address_b_layer_next,
  output logic [NUM_BANKS-1:0]            rden_a_bank,
  output logic [NUM_BANKS-1:0]            rden_b_bank,
  output logic [NUM_BANKS-1:0]            wren_a_bank,
  output logic [NUM_BANKS-1:0]            wren_b_bank,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] address_a_bank,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] address_b_bank,
  output logic [BANK_SEL_WIDTH-1:0]       wr_bank_sel,
  output logic [BANK_SEL_WIDTH-1:0]       rd_bank_sel,
  output logic [NUM_BANKS-1:0]            bank_full,
  output logic                            overflow_err
);

  typedef enum logic [1:0] {FIdle, FStart, FRun} former_state_e;
  typedef enum logic [1:0] {NIdle, NStart, NRun} next_state_e;

  former_state_e f_state_q;
  next_state_e   n_state_q;

  logic [BANK_SEL_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [NUM_BANKS-1:0]      bank_full_q, bank_full_d;
  logic                      former_done_q, next_done_q;
  logic                      overflow_q, overflow_d;

  logic former_edge, next_edge;
  logic former_commit, next_commit;

  function automatic logic [BANK_SEL_WIDTH-1:0] ptr_inc(input logic [BANK_SEL_WIDTH-1:0] ptr);
    if (ptr == BANK_SEL_WIDTH'(NUM_BANKS - 1)) return '0;
    return ptr + BANK_SEL_WIDTH'(1);
  endfunction

  // Done inputs are levels; only their rising edges mean anything.
  assign former_edge   = layer_former_done & ~former_done_q;
  assign next_edge     = layer_next_done & ~next_done_q;
  assign former_commit = former_edge & (f_state_q == FRun);
  assign next_commit   = next_edge & (n_state_q == NRun);

  always_comb begin
    wp_d        = former_commit ? ptr_inc(wp_q) : wp_q;
    rp_d        = next_commit ? ptr_inc(rp_q) : rp_q;
    bank_full_d = bank_full_q;
    // wp != rp whenever both commit together, so set and clear never collide.
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      if (former_commit && (wp_q == BANK_SEL_WIDTH'(k))) bank_full_d[k] = 1'b1;
      if (next_commit && (rp_q == BANK_SEL_WIDTH'(k)))   bank_full_d[k] = 1'b0;
    end
    unique case ({former_commit, next_commit})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    // A done edge outside RUN is a protocol error: flag it, never act on it.
    overflow_d = overflow_q
               | (former_edge & (f_state_q != FRun))
               | (next_edge & (n_state_q != NRun));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      former_done_q <= 1'b0;
      next_done_q   <= 1'b0;
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      bank_full_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      former_done_q <= layer_former_done;
      next_done_q   <= layer_next_done;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      bank_full_q   <= bank_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Former layer: start only while at least one bank is free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_state_q <= FIdle;
    end else begin
      unique case (f_state_q)
        FIdle:   if (enable && (count_q < CNT_WIDTH'(NUM_BANKS))) f_state_q <= FStart;
        FStart:  f_state_q <= FRun;
        FRun:    if (former_edge) f_state_q <= FIdle;
        default: f_state_q <= FIdle;
      endcase
    end
  end

  // Next layer: start only while at least one bank holds data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_state_q <= NIdle;
    end else begin
      unique case (n_state_q)
        NIdle:   if (enable && (count_q != '0)) n_state_q <= NStart;
        NStart:  n_state_q <= NRun;
        NRun:    if (next_edge) n_state_q <= NIdle;
        default: n_state_q <= NIdle;
      endcase
    end
  end

  assign layer_former_enable = (f_state_q == FRun);
  assign layer_former_reset  = (f_state_q == FStart);
  assign layer_next_enable   = (n_state_q == NRun);
  assign layer_next_reset    = (n_state_q == NStart);
  assign wr_bank_sel         = wp_q;
  assign rd_bank_sel         = rp_q;
  assign bank_full           = bank_full_q;
  assign overflow_err        = overflow_q;

  // Zero-latency routing from registered state; idle banks see all zeros.
  always_comb begin
    rden_a_bank    = '0;
    rden_b_bank    = '0;
    wren_a_bank    = '0;
    wren_b_bank    = '0;
    address_a_bank = '0;
    address_b_bank = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      if ((f_state_q == FRun) && (wp_q == BANK_SEL_WIDTH'(k))) begin
        rden_a_bank[k]                            = rden_a_layer_former;
        rden_b_bank[k]                            = rden_b_layer_former;
        wren_a_bank[k]                            = wren_a_layer_former;
        wren_b_bank[k]                            = wren_b_layer_former;
        address_a_bank[k*ADDR_WIDTH +: ADDR_WIDTH] = address_a_layer_former;
        address_b_bank[k*ADDR_WIDTH +: ADDR_WIDTH] = address_b_layer_former;
      end else if ((n_state_q == NRun) && (rp_q == BANK_SEL_WIDTH'(k))) begin
        rden_a_bank[k]                            = rden_a_layer_next;
        rden_b_bank[k]                            = rden_b_layer_next;
        address_a_bank[k*ADDR_WIDTH +: ADDR_WIDTH] = address_a_layer_next;
        address_b_bank[k*ADDR_WIDTH +: ADDR_WIDTH] = address_b_layer_next;
      end
    end
  end

endmodule
